ravenoc_edge_sink: RTL and testbench

// - Parametrised terminator for unconnected mesh-edge router ports; replaces fixed tie-off dummies.
// - Per port, runtime-selectable: TIE-OFF (ready held low, legacy) or SINK (accept and drop flits).
// - SINK mode tracks packet framing and counts dropped packets/flits.
// - Flags protocol errors, captures first dropped header, raises an IRQ so misrouted traffic is visible.

---
 rtl/ravenoc_edge_sink_if.sv | 13 +
 rtl/ravenoc_edge_sink.sv | 142 ++++++++++++++
 tb/tb_ravenoc_edge_sink.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ravenoc_edge_sink_if.sv
// Flit handshake bundle between a router edge port group and its terminator.
// master = router side driving flits, slave = terminator returning ready.
interface ravenoc_edge_sink_if #(
  parameter int NUM_PORTS  = 4,
  parameter int FLIT_WIDTH = 34
);
  logic [NUM_PORTS-1:0]            flit_valid;
  logic [NUM_PORTS*FLIT_WIDTH-1:0] flit_data;
  logic [NUM_PORTS-1:0]            flit_ready;

  modport master (output flit_valid, output flit_data, input  flit_ready);
  modport slave  (input  flit_valid, input  flit_data, output flit_ready);
endinterface

// File: rtl/ravenoc_edge_sink.sv
// Terminator for unconnected mesh-edge router ports: either ties ready low or
// sinks flits while tracking framing, counting drops and capturing the first header.
module ravenoc_edge_sink #(
  parameter int NUM_PORTS  = 4,
  parameter int FLIT_WIDTH = 34,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_noc,
  input  logic                            arst_noc,
  ravenoc_edge_sink_if.slave              flit_if,
  input  logic [NUM_PORTS-1:0]            sink_en_i,
  input  logic                            clear_i,
  input  logic                            irq_en_i,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_cnt_o,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  flit_cnt_o,
  output logic [NUM_PORTS-1:0]            proto_err_o,
  output logic [NUM_PORTS*FLIT_WIDTH-1:0] hdr_cap_o,
  output logic [NUM_PORTS-1:0]            hdr_vld_o,
  output logic                            irq_o
);

  localparam logic [1:0] TYPE_HEAD      = 2'b00;
  localparam logic [1:0] TYPE_BODY      = 2'b01;
  localparam logic [1:0] TYPE_TAIL      = 2'b10;
  localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Stage p0: registered ready; alive_p0 holds ready low for the first edge after reset.
  logic                 alive_p0;
  logic [NUM_PORTS-1:0] ready_p0;

  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      alive_p0 <= 1'b0;
      ready_p0 <= '0;
    end else begin
      alive_p0 <= 1'b1;
      ready_p0 <= alive_p0 ? sink_en_i : '0;
    end
  end

  assign flit_if.flit_ready = ready_p0;

  // Stage p1: per-port framing FSM, saturating counters, error flag and header capture.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [FLIT_WIDTH-1:0] flit;
    logic [1:0]            ftype;
    logic                  xfer;
    logic                  is_head;
    logic                  pkt_done;
    logic                  err_ev;

    state_t                state_p1;
    logic [CNT_WIDTH-1:0]  pkt_cnt_p1;
    logic [CNT_WIDTH-1:0]  flit_cnt_p1;
    logic                  err_p1;
    logic                  hdr_vld_p1;
    logic [FLIT_WIDTH-1:0] hdr_cap_p1;

    assign flit = flit_if.flit_data[p*FLIT_WIDTH +: FLIT_WIDTH];

    always_comb begin
      ftype    = flit[FLIT_WIDTH-1 -: 2];
      xfer     = flit_if.flit_valid[p] & ready_p0[p];
      is_head  = (ftype == TYPE_HEAD) || (ftype == TYPE_HEAD_TAIL);
      pkt_done = xfer && ((ftype == TYPE_HEAD_TAIL) ||
                          ((state_p1 == IN_PKT) && (ftype == TYPE_TAIL)));
      // A header inside a packet or a body/tail outside one both break framing.
      err_ev   = xfer && ((state_p1 == IDLE) ? !is_head : is_head);
    end

    always_ff @(posedge clk_noc or posedge arst_noc) begin
      if (arst_noc) begin
        state_p1 <= IDLE;
      end else if (!sink_en_i[p]) begin
        state_p1 <= IDLE;
      end else if (xfer) begin
        case (ftype)
          TYPE_HEAD:      state_p1 <= IN_PKT;
          TYPE_HEAD_TAIL: state_p1 <= IDLE;
          TYPE_TAIL:      state_p1 <= IDLE;
          TYPE_BODY:      state_p1 <= state_p1;
          default:        state_p1 <= IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_noc or posedge arst_noc) begin
      if (arst_noc) begin
        pkt_cnt_p1  <= '0;
        flit_cnt_p1 <= '0;
        err_p1      <= 1'b0;
        hdr_vld_p1  <= 1'b0;
        hdr_cap_p1  <= '0;
      end else if (clear_i) begin
        pkt_cnt_p1  <= '0;
        flit_cnt_p1 <= '0;
        err_p1      <= 1'b0;
        hdr_vld_p1  <= 1'b0;
        hdr_cap_p1  <= '0;
      end else begin
        if (xfer)     flit_cnt_p1 <= sat_inc(flit_cnt_p1);
        if (pkt_done) pkt_cnt_p1  <= sat_inc(pkt_cnt_p1);
        if (err_ev)   err_p1      <= 1'b1;
        if (xfer && is_head && !hdr_vld_p1) begin
          hdr_vld_p1 <= 1'b1;
          hdr_cap_p1 <= flit;
        end
      end
    end

    assign pkt_cnt_o[p*CNT_WIDTH +: CNT_WIDTH]    = pkt_cnt_p1;
    assign flit_cnt_o[p*CNT_WIDTH +: CNT_WIDTH]   = flit_cnt_p1;
    assign proto_err_o[p]                         = err_p1;
    assign hdr_vld_o[p]                           = hdr_vld_p1;
    assign hdr_cap_o[p*FLIT_WIDTH +: FLIT_WIDTH]  = hdr_cap_p1;
  end

  // Stage p2: interrupt follows the sticky flags by one cycle.
  logic irq_p2;

  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      irq_p2 <= 1'b0;
    end else begin
      irq_p2 <= irq_en_i & (|(hdr_vld_o | proto_err_o));
    end
  end

  assign irq_o = irq_p2;

endmodule

// File: tb/tb_ravenoc_edge_sink.sv
// Scoreboard bench for ravenoc_edge_sink: a 4-port 16-bit-counter instance
// plus a 1-port 2-bit-counter instance for saturation.
module tb_ravenoc_edge_sink;
  localparam int NP    = 4;
  localparam int FW    = 34;
  localparam int CW    = 16;
  localparam int CWS   = 2;
  localparam int SMALL = 99;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] sink_en;
  logic          sink_en_s;
  logic          clear;
  logic          irq_en;

  logic [NP*CW-1:0] pkt_cnt, flit_cnt;
  logic [NP-1:0]    proto_err, hdr_vld;
  logic [NP*FW-1:0] hdr_cap;
  logic             irq;

  logic [CWS-1:0]   pkt_cnt_s, flit_cnt_s;
  logic             proto_err_s, hdr_vld_s;
  logic [FW-1:0]    hdr_cap_s;
  logic             irq_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ravenoc_edge_sink_if #(.NUM_PORTS(NP), .FLIT_WIDTH(FW)) bus ();
  ravenoc_edge_sink_if #(.NUM_PORTS(1),  .FLIT_WIDTH(FW)) bus_s ();

  ravenoc_edge_sink #(.NUM_PORTS(NP), .FLIT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk_noc(clk), .arst_noc(rst), .flit_if(bus.slave),
    .sink_en_i(sink_en), .clear_i(clear), .irq_en_i(irq_en),
    .pkt_cnt_o(pkt_cnt), .flit_cnt_o(flit_cnt), .proto_err_o(proto_err),
    .hdr_cap_o(hdr_cap), .hdr_vld_o(hdr_vld), .irq_o(irq)
  );

  ravenoc_edge_sink #(.NUM_PORTS(1), .FLIT_WIDTH(FW), .CNT_WIDTH(CWS)) dut_s (
    .clk_noc(clk), .arst_noc(rst), .flit_if(bus_s.slave),
    .sink_en_i(sink_en_s), .clear_i(clear), .irq_en_i(irq_en),
    .pkt_cnt_o(pkt_cnt_s), .flit_cnt_o(flit_cnt_s), .proto_err_o(proto_err_s),
    .hdr_cap_o(hdr_cap_s), .hdr_vld_o(hdr_vld_s), .irq_o(irq_s)
  );

  typedef struct {
    string       tag;
    int          port;
    logic [15:0] pkt;
    logic [15:0] flit;
    logic        err;
    logic        hv;
    logic [33:0] hdr;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int port, input logic [15:0] pkt,
                          input logic [15:0] flit, input logic err, input logic hv,
                          input logic [33:0] hdr);
    exp_t e;
    e.tag = tag; e.port = port; e.pkt = pkt; e.flit = flit;
    e.err = err; e.hv = hv; e.hdr = hdr;
    sb.push_back(e);
  endtask

  // Pops every pending expectation and compares against the addressed port.
  task automatic drain();
    exp_t        e;
    logic [15:0] g_pkt, g_flit;
    logic        g_err, g_hv;
    logic [33:0] g_hdr;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port == SMALL) begin
        g_pkt = 16'(pkt_cnt_s); g_flit = 16'(flit_cnt_s);
        g_err = proto_err_s;    g_hv = hdr_vld_s; g_hdr = hdr_cap_s;
      end else begin
        g_pkt  = pkt_cnt[e.port*CW +: CW];
        g_flit = flit_cnt[e.port*CW +: CW];
        g_err  = proto_err[e.port];
        g_hv   = hdr_vld[e.port];
        g_hdr  = hdr_cap[e.port*FW +: FW];
      end
      check_eq({e.tag, "_pkt"},  64'(g_pkt),  64'(e.pkt));
      check_eq({e.tag, "_flit"}, 64'(g_flit), 64'(e.flit));
      check_eq({e.tag, "_err"},  64'(g_err),  64'(e.err));
      check_eq({e.tag, "_hv"},   64'(g_hv),   64'(e.hv));
      check_eq({e.tag, "_hdr"},  64'(g_hdr),  64'(e.hdr));
    end
  endtask

  // Called at a negedge; returns at the negedge after the flit was consumed.
  task automatic send(input int p, input logic [33:0] f);
    int budget = 20;
    bus.flit_valid[p] = 1'b1;
    bus.flit_data[p*FW +: FW] = f;
    while (!bus.flit_ready[p] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.flit_ready[p]) check_eq("ready_wait", 64'(bus.flit_ready[p]), 64'd1);
    else @(negedge clk);
  endtask

  task automatic send_s(input logic [33:0] f);
    int budget = 20;
    bus_s.flit_valid[0] = 1'b1;
    bus_s.flit_data = f;
    while (!bus_s.flit_ready[0] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus_s.flit_ready[0]) check_eq("ready_wait_s", 64'(bus_s.flit_ready[0]), 64'd1);
    else @(negedge clk);
  endtask

  task automatic idle();
    bus.flit_valid   = '0;
    bus_s.flit_valid = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [31:0] pl);
    return {t, pl};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic        seen;
    logic [33:0] h0, h2, h3, hs;

    rst = 1'b1; sink_en = '0; sink_en_s = 1'b0; clear = 1'b0; irq_en = 1'b1;
    bus.flit_valid = '0; bus.flit_data = '0;
    bus_s.flit_valid = '0; bus_s.flit_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(bus.flit_ready), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    check_eq("rst_cnt", 64'(pkt_cnt | flit_cnt), 64'd0);
    rst = 1'b0;

    // Tie-off mode: valid held with ready staying low.
    bus.flit_valid = '1;
    bus.flit_data = {NP{mk(2'b01, 32'h1111_1111)}};
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | (|bus.flit_ready);
    end
    check_eq("t1_ready", 64'(seen), 64'd0);
    check_eq("t1_cnt", 64'(pkt_cnt | flit_cnt), 64'd0);
    check_eq("t1_irq", 64'(irq), 64'd0);
    idle();

    // Single well-formed packet on port 0.
    sink_en[0] = 1'b1;
    @(negedge clk);
    check_eq("t2_ready", 64'(bus.flit_ready[0]), 64'd1);
    h0 = mk(2'b00, 32'hA000_0001);
    send(0, h0);
    send(0, mk(2'b01, 32'hA000_0002));
    send(0, mk(2'b01, 32'hA000_0003));
    send(0, mk(2'b10, 32'hA000_0004));
    idle();
    push_exp("t2", 0, 16'd1, 16'd4, 1'b0, 1'b1, h0);
    drain();
    @(negedge clk);
    check_eq("t2_irq", 64'(irq), 64'd1);

    // Body in IDLE on port 1, then global clear.
    sink_en[1] = 1'b1;
    @(negedge clk);
    send(1, mk(2'b01, 32'hB000_0001));
    idle();
    push_exp("t3", 1, 16'd0, 16'd1, 1'b1, 1'b0, 34'd0);
    drain();
    pulse_clear();
    push_exp("t3c1", 1, 16'd0, 16'd0, 1'b0, 1'b0, 34'd0);
    push_exp("t3c0", 0, 16'd0, 16'd0, 1'b0, 1'b0, 34'd0);
    drain();
    repeat (2) @(negedge clk);
    check_eq("t3_irq", 64'(irq), 64'd0);

    // Saturation on the 2-bit instance.
    sink_en_s = 1'b1;
    @(negedge clk);
    hs = mk(2'b11, 32'hC000_0000);
    send_s(hs);
    for (int i = 1; i < 5; i++) send_s(mk(2'b11, 32'hC000_0000 + 32'(i)));
    idle();
    push_exp("t4", SMALL, 16'd3, 16'd3, 1'b0, 1'b1, hs);
    drain();

    // clear coincident with a tail: nothing counted, FSM returns to IDLE.
    sink_en[3] = 1'b1;
    @(negedge clk);
    send(3, mk(2'b00, 32'hD000_0001));
    clear = 1'b1;
    send(3, mk(2'b10, 32'hD000_0002));
    clear = 1'b0;
    idle();
    push_exp("t5c", 3, 16'd0, 16'd0, 1'b0, 1'b0, 34'd0);
    drain();
    h3 = mk(2'b11, 32'hD000_0003);
    send(3, h3);
    idle();
    push_exp("t5", 3, 16'd1, 16'd1, 1'b0, 1'b1, h3);
    drain();

    // Mid-packet disable on port 2, then a stray tail after re-enable.
    sink_en[2] = 1'b1;
    @(negedge clk);
    h2 = mk(2'b00, 32'hE000_0001);
    send(2, h2);
    send(2, mk(2'b01, 32'hE000_0002));
    idle();
    sink_en[2] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_ready_off", 64'(bus.flit_ready[2]), 64'd0);
    push_exp("t6gap", 2, 16'd0, 16'd2, 1'b0, 1'b1, h2);
    drain();
    sink_en[2] = 1'b1;
    @(negedge clk);
    send(2, mk(2'b10, 32'hE000_0003));
    idle();
    push_exp("t6", 2, 16'd0, 16'd3, 1'b1, 1'b1, h2);
    drain();

    // Asynchronous reset in the middle of a packet.
    send(2, mk(2'b00, 32'hE000_0004));
    #1 rst = 1'b1;
    #1;
    check_eq("ar_ready", 64'(bus.flit_ready), 64'd0);
    check_eq("ar_pkt",   64'(pkt_cnt), 64'd0);
    check_eq("ar_flit",  64'(flit_cnt), 64'd0);
    check_eq("ar_err",   64'(proto_err), 64'd0);
    check_eq("ar_hv",    64'(hdr_vld), 64'd0);
    check_eq("ar_hdr",   64'(|hdr_cap), 64'd0);
    check_eq("ar_irq",   64'(irq), 64'd0);
    check_eq("ar_small", 64'({pkt_cnt_s, flit_cnt_s, hdr_vld_s, irq_s}), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
